// File: rtl/mac_arbiter_if.sv
// Bus between NREQ requesters, the round-robin MAC arbiter and the shared MAC16 unit.
// The arbiter takes the slave view; requesters plus the MAC form the master side.
interface mac_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [16*NREQ-1:0]   req_a;
    logic [16*NREQ-1:0]   req_b;
    logic [16*NREQ-1:0]   req_c;
    logic signed [15:0]   mac_a;
    logic signed [15:0]   mac_b;
    logic signed [15:0]   mac_c;
    logic signed [31:0]   mac_result;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic signed [31:0]   rsp_data;
    logic                 busy;

    modport slave (
        input  req_valid, req_a, req_b, req_c, mac_result,
        output req_ready, mac_a, mac_b, mac_c, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_c, mac_result,
        input  req_ready, mac_a, mac_b, mac_c, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one pipelined MAC16 among NREQ requesters.
// Responses are matched to requesters by a {valid, id} tag pipeline aligned to the MAC latency.
module mac_arbiter #(
    parameter int NREQ    = 4,
    parameter int MAC_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    mac_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     ptr_d;
    logic [NREQ-1:0]    grant_oh;
    logic [IDW-1:0]     grant_idx;
    logic               accept;
    logic signed [15:0] mac_a_q;
    logic signed [15:0] mac_b_q;
    logic signed [15:0] mac_c_q;
    logic [MAC_LAT:0]   tag_valid_q;
    logic [IDW-1:0]     tag_id_q [MAC_LAT+1];

    // Scan downward so the candidate closest to ptr (lowest offset) is written last and wins.
    // NOTE: every variable is given a default at the top of the block, so no path leaves one unassigned and infers a latch.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        accept    = 1'b0;
        ptr_d     = ptr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(ptr_q) + k) % NREQ]) begin
                grant_idx = IDW'((int'(ptr_q) + k) % NREQ);
                accept    = 1'b1;
            end
        end
        if (reset) begin
            accept = 1'b0;
        end
        if (accept) begin
            grant_oh[grant_idx] = 1'b1;
            ptr_d = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_c_q     <= '0;
            tag_valid_q <= '0;
            // NOTE: the id stages are a handful of flops, not a RAM, so clearing them is cheap and makes rsp_id read 0 out of reset.
            for (int s = 0; s <= MAC_LAT; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            tag_valid_q <= {tag_valid_q[MAC_LAT-1:0], accept};
            tag_id_q[0] <= accept ? grant_idx : '0;
            for (int s = 1; s <= MAC_LAT; s++) begin
                tag_id_q[s] <= tag_id_q[s-1];
            end
            if (accept) begin
                mac_a_q <= bus.req_a[int'(grant_idx)*16 +: 16];
                mac_b_q <= bus.req_b[int'(grant_idx)*16 +: 16];
                mac_c_q <= bus.req_c[int'(grant_idx)*16 +: 16];
            end
        end
    end

    assign bus.req_ready = grant_oh;
    assign bus.mac_a     = mac_a_q;
    assign bus.mac_b     = mac_b_q;
    assign bus.mac_c     = mac_c_q;
    assign bus.rsp_valid = tag_valid_q[MAC_LAT];
    assign bus.rsp_id    = tag_id_q[MAC_LAT];
    assign bus.rsp_data  = bus.mac_result;
    assign bus.busy      = |tag_valid_q;
endmodule

// File: tb/tb_mac_arbiter.sv
// Self-checking bench for mac_arbiter: a queue-based round-robin/response model for a MAC_LAT=1
// instance plus a directed operand-capture scenario on a MAC_LAT=3 instance.
module tb_mac_arbiter;
    localparam int NREQ = 4;
    localparam int LAT1 = 1;
    localparam int LAT2 = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_arbiter_if #(.NREQ(NREQ)) bus1 ();
    mac_arbiter_if #(.NREQ(NREQ)) bus2 ();

    mac_arbiter #(.NREQ(NREQ), .MAC_LAT(LAT1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mac_arbiter #(.NREQ(NREQ), .MAC_LAT(LAT2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    function automatic logic signed [31:0] mac_fn(input logic signed [15:0] a,
                                                  input logic signed [15:0] b,
                                                  input logic signed [15:0] c);
        int ia, ib, ic;
        ia = a;
        ib = b;
        ic = c;
        return ia * ib + ic;
    endfunction

    // Shared MAC16 models: result appears MAC_LAT cycles after the operands.
    logic signed [31:0] pipe1 [LAT1];
    logic signed [31:0] pipe2 [LAT2];
    always @(posedge clk) begin
        pipe1[0] <= mac_fn(bus1.mac_a, bus1.mac_b, bus1.mac_c);
        pipe2[0] <= mac_fn(bus2.mac_a, bus2.mac_b, bus2.mac_c);
        for (int i = 1; i < LAT2; i++) begin
            pipe2[i] <= pipe2[i-1];
        end
    end
    assign bus1.mac_result = pipe1[LAT1-1];
    assign bus2.mac_result = pipe2[LAT2-1];

    typedef struct {
        int                 id;
        logic signed [31:0] data;
        int                 due;
    } rsp_t;

    rsp_t               exp_q[$];
    int                 m_ptr;
    int                 m_cyc;
    logic signed [15:0] exp_mac_a, exp_mac_b, exp_mac_c;
    logic signed [15:0] op_a [NREQ];
    logic signed [15:0] op_b [NREQ];
    logic signed [15:0] op_c [NREQ];
    int                 log_id[$];
    int                 log_cyc[$];
    logic signed [31:0] log_data[$];
    int                 checks;
    int                 failures;

    task automatic clear_log;
        log_id.delete();
        log_cyc.delete();
        log_data.delete();
    endtask

    task automatic rand_ops;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = 16'($urandom);
            op_b[i] = 16'($urandom);
            op_c[i] = 16'($urandom);
        end
    endtask

    // One clock of dut1 against the reference model: predicted grant, responses, busy and MAC operands.
    task automatic run_cycle(input logic rst, input logic [NREQ-1:0] valid, output logic [NREQ-1:0] rdy);
        int              g;
        logic [NREQ-1:0] exp_rdy;
        logic            exp_rv;
        rsp_t            r;
        reset          = rst;
        bus1.req_valid = valid;
        for (int i = 0; i < NREQ; i++) begin
            bus1.req_a[16*i +: 16] = op_a[i];
            bus1.req_b[16*i +: 16] = op_b[i];
            bus1.req_c[16*i +: 16] = op_c[i];
        end
        g = -1;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;

        @(negedge clk);
        rdy = bus1.req_ready;
        checks++;
        if (rdy !== exp_rdy) begin
            failures++;
            $display("FAIL req_ready cyc=%0d: got %b expected %b", m_cyc, rdy, exp_rdy);
        end
        if (!rst) begin
            exp_rv = (exp_q.size() != 0) && (exp_q[0].due == m_cyc);
            checks++;
            if (bus1.rsp_valid !== exp_rv) begin
                failures++;
                $display("FAIL rsp_valid cyc=%0d: got %b expected %b", m_cyc, bus1.rsp_valid, exp_rv);
            end
            checks++;
            if (bus1.busy !== (exp_q.size() != 0)) begin
                failures++;
                $display("FAIL busy cyc=%0d: got %b expected %b", m_cyc, bus1.busy, exp_q.size() != 0);
            end
            checks++;
            if ({bus1.mac_a, bus1.mac_b, bus1.mac_c} !== {exp_mac_a, exp_mac_b, exp_mac_c}) begin
                failures++;
                $display("FAIL mac_operands cyc=%0d: got %h/%h/%h expected %h/%h/%h", m_cyc,
                         bus1.mac_a, bus1.mac_b, bus1.mac_c, exp_mac_a, exp_mac_b, exp_mac_c);
            end
            if (bus1.rsp_valid === 1'b1) begin
                log_id.push_back(int'(bus1.rsp_id));
                log_cyc.push_back(m_cyc);
                log_data.push_back(bus1.rsp_data);
            end
            if (exp_rv) begin
                r = exp_q.pop_front();
                checks++;
                if (int'(bus1.rsp_id) !== r.id || bus1.rsp_data !== r.data) begin
                    failures++;
                    $display("FAIL rsp_payload cyc=%0d: got id=%0d data=%h expected id=%0d data=%h",
                             m_cyc, bus1.rsp_id, bus1.rsp_data, r.id, r.data);
                end
            end
        end

        if (rst) begin
            exp_q.delete();
            m_ptr     = 0;
            exp_mac_a = '0;
            exp_mac_b = '0;
            exp_mac_c = '0;
        end else if (g >= 0) begin
            r.id   = g;
            r.data = mac_fn(op_a[g], op_b[g], op_c[g]);
            r.due  = m_cyc + 1 + LAT1;
            exp_q.push_back(r);
            exp_mac_a = op_a[g];
            exp_mac_b = op_b[g];
            exp_mac_c = op_c[g];
            m_ptr     = (g + 1) % NREQ;
        end
        @(posedge clk);
        #1;
        m_cyc++;
    endtask

    task automatic idle(input int n);
        logic [NREQ-1:0] rdy;
        for (int i = 0; i < n; i++) run_cycle(1'b0, '0, rdy);
    endtask

    task automatic test_reset;
        logic [NREQ-1:0] rdy;
        rand_ops();
        run_cycle(1'b1, 4'hF, rdy);
        run_cycle(1'b1, 4'hF, rdy);
        checks++;
        if (rdy !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 0000", rdy);
        end
        checks++;
        if ({bus1.rsp_valid, bus1.busy, bus1.rsp_id} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b busy=%b id=%0d expected all 0",
                     bus1.rsp_valid, bus1.busy, bus1.rsp_id);
        end
        checks++;
        if ({bus1.mac_a, bus1.mac_b, bus1.mac_c} !== 48'd0) begin
            failures++;
            $display("FAIL reset_mac: got %h/%h/%h expected 0", bus1.mac_a, bus1.mac_b, bus1.mac_c);
        end
        run_cycle(1'b0, 4'hF, rdy);
        checks++;
        if (rdy !== 4'b0001) begin
            failures++;
            $display("FAIL first_grant_after_reset: got %b expected 0001", rdy);
        end
        idle(3);
    endtask

    task automatic test_single_op;
        logic [NREQ-1:0] rdy;
        int              t;
        run_cycle(1'b1, '0, rdy);
        clear_log();
        op_a[2] = 16'hFFFB;
        op_b[2] = 16'h0003;
        op_c[2] = 16'h000A;
        t = m_cyc;
        run_cycle(1'b0, 4'b0100, rdy);
        checks++;
        if (rdy !== 4'b0100) begin
            failures++;
            $display("FAIL single_grant: got %b expected 0100", rdy);
        end
        idle(3);
        checks++;
        if (log_id.size() != 1) begin
            failures++;
            $display("FAIL single_rsp_count: got %0d expected 1", log_id.size());
        end else if (log_cyc[0] != t + 2 || log_id[0] != 2 || log_data[0] !== 32'hFFFFFFFB) begin
            failures++;
            $display("FAIL single_rsp: got cyc=+%0d id=%0d data=%h expected cyc=+2 id=2 data=fffffffb",
                     log_cyc[0] - t, log_id[0], log_data[0]);
        end
    endtask

    task automatic test_fairness;
        logic [NREQ-1:0] rdy;
        logic [NREQ-1:0] e;
        int              t;
        run_cycle(1'b1, '0, rdy);
        clear_log();
        t = m_cyc;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            run_cycle(1'b0, 4'hF, rdy);
            e = 4'b0001 << (i % 4);
            checks++;
            if (rdy !== e) begin
                failures++;
                $display("FAIL fair_grant[%0d]: got %b expected %b", i, rdy, e);
            end
        end
        idle(3);
        checks++;
        if (log_id.size() != 8) begin
            failures++;
            $display("FAIL fair_rsp_count: got %0d expected 8", log_id.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (log_id[i] != i % 4 || log_cyc[i] != t + 2 + i) begin
                    failures++;
                    $display("FAIL fair_rsp[%0d]: got id=%0d cyc=+%0d expected id=%0d cyc=+%0d",
                             i, log_id[i], log_cyc[i] - t, i % 4, 2 + i);
                end
            end
        end
    endtask

    task automatic test_ptr_wrap;
        logic [NREQ-1:0] rdy;
        run_cycle(1'b1, '0, rdy);
        rand_ops();
        clear_log();
        run_cycle(1'b0, 4'b0010, rdy);
        op_a[3] = -16'sd32768;
        op_b[3] = -16'sd32768;
        op_c[3] = 16'sd0;
        run_cycle(1'b0, 4'b1010, rdy);
        checks++;
        if (rdy !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_first: got %b expected 1000", rdy);
        end
        run_cycle(1'b0, 4'b1010, rdy);
        checks++;
        if (rdy !== 4'b0010) begin
            failures++;
            $display("FAIL wrap_second: got %b expected 0010", rdy);
        end
        idle(3);
        checks++;
        if (log_id.size() != 3) begin
            failures++;
            $display("FAIL wrap_rsp_count: got %0d expected 3", log_id.size());
        end else if (log_id[1] != 3 || log_data[1] !== 32'h40000000 || log_id[2] != 1) begin
            failures++;
            $display("FAIL wrap_rsp: got id=%0d data=%h next=%0d expected id=3 data=40000000 next=1",
                     log_id[1], log_data[1], log_id[2]);
        end
    endtask

    task automatic test_reset_mid;
        logic [NREQ-1:0] rdy;
        run_cycle(1'b1, '0, rdy);
        rand_ops();
        run_cycle(1'b0, 4'hF, rdy);
        run_cycle(1'b0, 4'hF, rdy);
        run_cycle(1'b1, 4'hF, rdy);
        clear_log();
        idle(4);
        checks++;
        if (log_id.size() != 0 || bus1.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_flush: got rsp_count=%0d busy=%b expected 0 and 0", log_id.size(), bus1.busy);
        end
        checks++;
        if ({bus1.mac_a, bus1.mac_b, bus1.mac_c} !== 48'd0) begin
            failures++;
            $display("FAIL reset_mid_mac: got %h/%h/%h expected 0", bus1.mac_a, bus1.mac_b, bus1.mac_c);
        end
        run_cycle(1'b0, 4'hF, rdy);
        checks++;
        if (rdy !== 4'b0001) begin
            failures++;
            $display("FAIL reset_mid_ptr: got %b expected 0001", rdy);
        end
        idle(3);
    endtask

    task automatic test_idle;
        logic [NREQ-1:0]    rdy;
        logic signed [47:0] held;
        run_cycle(1'b1, '0, rdy);
        rand_ops();
        run_cycle(1'b0, 4'b0001, rdy);
        held = {op_a[0], op_b[0], op_c[0]};
        rand_ops();
        idle(5);
        checks++;
        if ({bus1.mac_a, bus1.mac_b, bus1.mac_c} !== held || bus1.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: got mac=%h busy=%b expected mac=%h busy=0",
                     {bus1.mac_a, bus1.mac_b, bus1.mac_c}, bus1.busy, held);
        end
        run_cycle(1'b0, 4'hF, rdy);
        checks++;
        if (rdy !== 4'b0010) begin
            failures++;
            $display("FAIL idle_ptr: got %b expected 0010", rdy);
        end
        idle(3);
    endtask

    task automatic test_random;
        logic [NREQ-1:0] rdy;
        logic [NREQ-1:0] v;
        run_cycle(1'b1, '0, rdy);
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            v = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) v = '0;
            run_cycle($urandom_range(0, 59) == 0, v, rdy);
        end
        idle(4);
        checks++;
        if (bus1.busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL random_drain: got busy=%b pending=%0d expected 0 and 0", bus1.busy, exp_q.size());
        end
    endtask

    task automatic test_operand_hold;
        int                 t_rsp;
        int                 n_rsp;
        logic signed [31:0] d_rsp;
        logic signed [31:0] expv;
        reset          = 1'b0;
        bus1.req_valid = '0;
        expv           = mac_fn(16'sd1234, -16'sd7, 16'sd100);
        bus2.req_a     = '0;
        bus2.req_b     = '0;
        bus2.req_c     = '0;
        bus2.req_a[15:0] = 16'sd1234;
        bus2.req_b[15:0] = -16'sd7;
        bus2.req_c[15:0] = 16'sd100;
        bus2.req_valid   = 4'b0001;
        @(negedge clk);
        checks++;
        if (bus2.req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL hold_grant: got %b expected 0001", bus2.req_ready);
        end
        @(posedge clk);
        #1;
        bus2.req_a[15:0] = 16'sd999;
        bus2.req_valid   = '0;
        t_rsp = -1;
        n_rsp = 0;
        d_rsp = '0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (bus2.mac_a !== 16'sd1234) begin
                    failures++;
                    $display("FAIL hold_mac_a: got %0d expected 1234", bus2.mac_a);
                end
            end
            if (bus2.rsp_valid === 1'b1) begin
                n_rsp++;
                if (t_rsp < 0) begin
                    t_rsp = k;
                    d_rsp = bus2.rsp_data;
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (n_rsp != 1 || t_rsp != 4 || d_rsp !== expv) begin
            failures++;
            $display("FAIL hold_rsp: got count=%0d at=T+%0d data=%h expected count=1 at=T+4 data=%h",
                     n_rsp, t_rsp, d_rsp, expv);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        checks         = 0;
        failures       = 0;
        m_ptr          = 0;
        m_cyc          = 0;
        reset          = 1'b1;
        bus1.req_valid = '0;
        bus1.req_a     = '0;
        bus1.req_b     = '0;
        bus1.req_c     = '0;
        bus2.req_valid = '0;
        bus2.req_a     = '0;
        bus2.req_b     = '0;
        bus2.req_c     = '0;
        exp_mac_a      = '0;
        exp_mac_b      = '0;
        exp_mac_c      = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_op();
        test_fairness();
        test_ptr_wrap();
        test_reset_mid();
        test_idle();
        test_random();
        test_operand_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters sharing the MAC (2..8).
REQ-002 Parameter: MAC_LAT, default 1, cycles from operands presented on mac_a/b/c to matching mac_result.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester grant/accept, one-hot or zero.
REQ-007 req_a, req_b, req_c  input  16*NREQ each  packed signed operands; slice i belongs to requester i.
REQ-008 mac_a, mac_b, mac_c  output  16 each  signed operands to the shared MAC16 wrapper.
REQ-009 mac_result  input  32  signed a*b+c from the MAC, MAC_LAT cycles after operands.
REQ-010 rsp_valid  output  1  response strobe, one cycle per accepted request.
REQ-011 rsp_id  output  clog2(NREQ)  requester index of the response.
REQ-012 rsp_data  output  32  signed result of the response.
REQ-013 busy  output  1  high while any accepted operation has no response yet.

Function
REQ-014 Handshake: request i accepted in a cycle iff req_valid[i] && req_ready[i].
REQ-015 req_ready is combinational from req_valid and rr pointer; at most one bit high per cycle; req_ready[i] never high while req_valid[i] low.
REQ-016 Round-robin: grant the first asserted req_valid at index ptr, ptr+1, ... wrapping NREQ-1 -> 0.
REQ-017 ptr <= granted index + 1 (mod NREQ) after a grant; unchanged in cycles with no grant.
REQ-018 Fairness: with k requesters continuously valid, each granted exactly once per k consecutive cycles.
REQ-019 Throughput: one acceptance per cycle whenever any req_valid is high; no bubbles.
REQ-020 On acceptance in cycle T, granted slices of req_a/b/c registered onto mac_a/b/c, presented in cycle T+1.
REQ-021 mac_a/b/c hold their last value in cycles with no acceptance.
REQ-022 Tag pipeline: shift register of depth MAC_LAT+1 carrying {valid, id}; valid=1 only for accepted cycles.
REQ-023 Request accepted in cycle T produces rsp_valid=1 in cycle T+1+MAC_LAT exactly, with rsp_id = its index.
REQ-024 rsp_data = mac_result in every cycle rsp_valid is high; value don't-care otherwise.
REQ-025 No response backpressure; responses emitted strictly in acceptance order, never dropped or duplicated.
REQ-026 Arbiter performs no arithmetic; width/sign of result is the MAC's signed 16x16+16 -> 32.
REQ-027 Same requester may be accepted in consecutive cycles only if no other req_valid is high.
REQ-028 busy = OR of tag-pipeline valid bits; low when no operation in flight.
REQ-029 Operands are sampled only in the acceptance cycle; later changes to req_a/b/c do not affect that result.

Reset
REQ-030 While reset high: req_ready = 0, no acceptance regardless of req_valid.
REQ-031 After reset: ptr = 0, all tags cleared, rsp_valid = 0, rsp_id = 0, busy = 0, mac_a/b/c = 0.
REQ-032 Reset mid-operation discards all in-flight operations; no rsp_valid in any cycle following reset assertion until a new acceptance completes.
REQ-033 First cycle after reset deasserts, arbitration starts at requester 0.

Verification
REQ-034 Single op: MAC_LAT=1, req 2 only, a=0xFFFB, b=0x0003, c=0x000A accepted at T -> rsp_valid at T+2, rsp_id=2, rsp_data=0xFFFFFFFB.
REQ-035 All 4 valid continuously for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; responses same order, one per cycle, no gaps.
REQ-036 Req 1 and 3 valid, ptr=2 -> req 3 granted first, then 1; req 3 operands a=-32768, b=-32768, c=0 -> rsp_data=0x40000000.
REQ-037 Reset asserted one cycle after two acceptances -> no rsp_valid thereafter, busy=0, ptr=0, mac_a/b/c=0.
REQ-038 MAC_LAT=3, req 0 changes req_a the cycle after acceptance -> response uses originally sampled operands, rsp_valid at T+4.
REQ-039 All req_valid low for 5 cycles -> req_ready=0, rsp_valid=0, busy=0, mac_a/b/c unchanged, ptr unchanged.
